// File: rtl/spi_v_pkg.sv
// Shared constants for the SPI slave receiver/echo block.
//   FRAME_LEN : SCK falling edges per frame
//   DATA_W    : width of the parallel word taken from the frame MSBs
//   DATA_LSB  : lowest frame bit kept in DataOut (bits below are dropped)
//   CNT_W     : width of the frame bit counter
package spi_v_pkg;

  localparam int unsigned FRAME_LEN = 16;
  localparam int unsigned DATA_W    = 11;
  localparam int unsigned DATA_LSB  = 5;
  localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/spi_shift_reg.sv
// Left-shifting register clocked on the falling edge of clk_i.
//   clk_i       : serial clock, state updates on its falling edge
//   rst_ni      : asynchronous active-low clear
//   load_i      : parallel load instead of shifting this edge
//   load_data_i : parallel load value
//   ser_i       : serial input, enters at bit 0
//   q_o         : register contents (MSB is the serial output)
module spi_shift_reg #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             ser_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = {q_q[Width-2:0], ser_i};
    if (load_i) begin
      q_d = load_data_i;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spi_v.sv
// SPI slave: receives MSB-first frames on SDI, publishes the frame MSBs on
// DataOut with a one-period SSPIF pulse, and echoes each frame on SDO during
// the following frame.
//   SCK     : serial clock (idles high), everything updates on its falling edge
//   Reset   : asynchronous active-low reset
//   SDI     : serial data in, sampled on SCK falling edges
//   SDO     : serial data out, MSB first, valid for master rising-edge sampling
//   DataOut : word[FRAME_LEN-1 -: DATA_W] of the last completed frame
//   SSPIF   : high for one SCK period after each completed frame
module spi_v
  import spi_v_pkg::*;
#(
  parameter int unsigned FRAME_LEN = spi_v_pkg::FRAME_LEN,
  parameter int unsigned DATA_W    = spi_v_pkg::DATA_W
) (
  input  logic              SCK,
  input  logic              Reset,
  input  logic              SDI,
  output logic              SDO,
  output logic [DATA_W-1:0] DataOut,
  output logic              SSPIF
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [DATA_W-1:0]    data_d, data_q;
  logic                 sspif_d, sspif_q;
  logic                 frame_done;
  logic [FRAME_LEN-1:0] rx_q, tx_q, word;

  assign frame_done = (cnt_q == LastCnt);
  // The final bit is still on SDI at the completing edge, so splice it in.
  assign word       = {rx_q[FRAME_LEN-2:0], SDI};

  always_comb begin
    cnt_d   = frame_done ? '0 : cnt_q + 1'b1;
    data_d  = data_q;
    sspif_d = frame_done;
    if (frame_done) begin
      data_d = word[FRAME_LEN-1 -: DATA_W];
    end
  end

  always_ff @(negedge SCK or negedge Reset) begin
    if (!Reset) begin
      cnt_q   <= '0;
      data_q  <= '0;
      sspif_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sspif_q <= sspif_d;
    end
  end

  spi_shift_reg #(
    .Width (FRAME_LEN)
  ) u_rx (
    .clk_i       (SCK),
    .rst_ni      (Reset),
    .load_i      (1'b0),
    .load_data_i ('0),
    .ser_i       (SDI),
    .q_o         (rx_q)
  );

  // Loads the just-completed word, then shifts it out behind zeros.
  spi_shift_reg #(
    .Width (FRAME_LEN)
  ) u_tx (
    .clk_i       (SCK),
    .rst_ni      (Reset),
    .load_i      (frame_done),
    .load_data_i (word),
    .ser_i       (1'b0),
    .q_o         (tx_q)
  );

  assign SDO     = tx_q[FRAME_LEN-1];
  assign DataOut = data_q;
  assign SSPIF   = sspif_q;

  // rx MSB is shifted out unused; tx only exposes its MSB.
  logic unused_bits;
  assign unused_bits = rx_q[FRAME_LEN-1] ^ (^tx_q[FRAME_LEN-2:0]);

endmodule

// File: tb/tb_spi_v.sv
module tb_spi_v;

  logic        SCK;
  logic        Reset;
  logic        SDI;
  logic        SDO;
  logic [10:0] DataOut;
  logic        SSPIF;

  spi_v u_dut (
    .SCK     (SCK),
    .Reset   (Reset),
    .SDI     (SDI),
    .SDO     (SDO),
    .DataOut (DataOut),
    .SSPIF   (SSPIF)
  );

  initial SCK = 1'b1;
  always #50 SCK = ~SCK;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bit stream since reset, frames every 16 bits.
  int          n_bits;
  logic [15:0] cur;
  logic [15:0] last_word;
  bit          have_word;
  int          since;
  logic [10:0] exp_data;
  logic        exp_sspif;
  logic [15:0] sdo_hist;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic exp_sdo();
    if (!have_word) return 1'b0;
    return last_word[15 - since];
  endfunction

  task automatic model_reset();
    n_bits    = 0;
    cur       = '0;
    last_word = '0;
    have_word = 0;
    since     = 0;
    exp_data  = '0;
    exp_sspif = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    cur = {cur[14:0], b};
    n_bits++;
    if (n_bits % 16 == 0) begin
      last_word = cur;
      have_word = 1;
      since     = 0;
      exp_data  = cur >> 5;
      exp_sspif = 1'b1;
    end else begin
      since++;
      exp_sspif = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("data", 16'(DataOut), 16'(exp_data));
    check("sspif", 16'(SSPIF), 16'(exp_sspif));
    check("sdo", 16'(SDO), 16'(exp_sdo()));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 16'(DataOut), 16'h0);
    check({tag, "_sspif"}, 16'(SSPIF), 16'h0);
    check({tag, "_sdo"}, 16'(SDO), 16'h0);
  endtask

  // Drive SDI at SCK rise (after sampling SDO), DUT takes it on the fall.
  task automatic send_bit(input logic b);
    @(posedge SCK);
    #1;
    check_outputs();
    sdo_hist = {sdo_hist[14:0], SDO};
    SDI = b;
    @(negedge SCK);
    #1;
    model_edge(b);
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  // Assert Reset mid-cycle, hold it across several edges, release between a
  // fall and the next rise so the next fall is the frame MSB.
  task automatic pulse_reset();
    @(posedge SCK);
    #10;
    Reset = 1'b0;
    #1;
    model_reset();
    check_zero("rst_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge SCK);
      #1;
      check_zero("rst_hold");
    end
    #10;
    Reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w;
    Reset    = 1'b0;
    SDI      = 1'b0;
    sdo_hist = '0;
    model_reset();

    // Held in reset while SCK toggles.
    for (int i = 0; i < 4; i++) begin
      @(posedge SCK);
      #1;
      SDI = 1'b1;
      check_zero("rst_init_rise");
      @(negedge SCK);
      #1;
      check_zero("rst_init_fall");
    end
    #10;
    SDI   = 1'b0;
    Reset = 1'b1;

    send_frame(16'h8000);
    check("f8000_data", 16'(DataOut), 16'h0400);
    check("f8000_sspif", 16'(SSPIF), 16'h1);

    send_frame(16'hFFFF);
    check("fffff_data", 16'(DataOut), 16'h07FF);
    check("fffff_sspif", 16'(SSPIF), 16'h1);
    send_frame(16'h0020);
    check("f0020_data", 16'(DataOut), 16'h0001);
    check("f0020_sspif", 16'(SSPIF), 16'h1);

    send_frame(16'hA5C3);
    sdo_hist = '0;
    send_frame(16'h0000);
    check("echo_a5c3", sdo_hist, 16'hA5C3);

    // Partial frame aborted by reset.
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(1, 0)));
    pulse_reset();
    send_frame(16'h001F);
    check("f001f_data", 16'(DataOut), 16'h0000);
    check("f001f_sspif", 16'(SSPIF), 16'h1);

    send_frame(16'hFFE0);
    send_frame(16'h0010);
    check("f0010_data", 16'(DataOut), 16'h0000);

    // Random back-to-back frames with a random-length aborted frame.
    for (int f = 0; f < 6; f++) begin
      w = 16'($urandom);
      send_frame(w);
      check("rand_data", 16'(DataOut), 16'(w[15:5]));
    end
    for (int i = 0; i < int'($urandom_range(14, 1)); i++) send_bit(1'($urandom_range(1, 0)));
    pulse_reset();
    for (int f = 0; f < 4; f++) begin
      w = 16'($urandom);
      sdo_hist = '0;
      send_frame(w);
      check("rand_data2", 16'(DataOut), 16'(w[15:5]));
    end
    w = '0;
    for (int i = 0; i < 16; i++) send_bit(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_v.md
SPI_V -- requirements
Module: spi_v

Interface
REQ-001 Parameter FRAME_LEN, default 16, SCK falling edges per frame.
REQ-002 Parameter DATA_W, default 11, width of DataOut, taken from the frame MSBs.
REQ-003 Clocking: one clock; reset is asynchronous and active-low. Clock port is SCK, reset port is Reset.
REQ-004 SCK  input  1  serial clock, idles high, sole clock of the block.
REQ-005 Reset  input  1  asynchronous active-low reset.
REQ-006 SDI  input  1  serial data in, MSB first, stable around each SCK falling edge.
REQ-007 SDO  output  1  serial data out, MSB first.
REQ-008 DataOut  output  DATA_W  last completed received word, bits [15:5] of the frame.
REQ-009 SSPIF  output  1  frame-complete flag.

Function
REQ-010 All sequential logic SHALL update on the SCK falling edge only; SDI is sampled there.
REQ-011 A 4-bit bit counter SHALL count falling edges 0..FRAME_LEN-1 and wrap from 15 to 0 with no idle gap required between frames.
REQ-012 On each falling edge the receive shift register SHALL shift left, taking SDI into bit 0.
REQ-013 On the falling edge where the counter equals 15, the full word is {rx[14:0], SDI}.
REQ-014 On that edge DataOut SHALL load word[15:5], SSPIF SHALL go high, and the transmit register SHALL load the full word.
REQ-015 SSPIF SHALL return low on the next falling edge, so it is high for exactly one SCK period.
REQ-016 DataOut SHALL hold its value between frame completions.
REQ-017 SDO SHALL equal the transmit register MSB, driven combinationally from the register.
REQ-018 The transmit register SHALL shift left, filling with 0, on every falling edge except the frame-completion edge.
REQ-019 Result: each frame is echoed on SDO during the following frame; the master samples SDO on SCK rising edges.
REQ-020 Word bits [4:0] SHALL be discarded.
REQ-021 A partial frame SHALL never update DataOut or SSPIF.

Reset
REQ-022 While Reset=0, the block SHALL asynchronously clear and hold all state: bit counter 0, receive register 0, transmit register 0, DataOut 0, SSPIF 0, SDO 0.
REQ-023 After Reset rises, the first SCK falling edge SHALL be treated as frame bit 15 (the MSB).
REQ-024 Reset asserted mid-frame SHALL abort the frame with no SSPIF pulse.

Structure
REQ-025 A shared package SHALL hold the constants FRAME_LEN=16, DATA_W=11, DATA_LSB=5 and the counter width 4.
REQ-026 One sub-module, spi_shift_reg, SHALL be used, instantiated twice: receive with serial-in, transmit with parallel load and serial-out.
REQ-027 The bit counter and flag logic SHALL reside in spi_v.

Verification
REQ-028 Reset=0 held while SCK toggles -> DataOut=0x000, SSPIF=0, SDO=0 throughout.
REQ-029 Reset=1, frame 0x8000 (1 then fifteen 0s, SDI set at SCK rise, 50 ns half-period) -> after the 16th falling edge DataOut=0x400 and SSPIF=1 for one SCK period.
REQ-030 Frame 0xFFFF then frame 0x0020 back-to-back -> DataOut=0x7FF, then 0x001, and one SSPIF pulse per frame.
REQ-031 Frame 0xA5C3 then 16 more clocks -> SDO sampled on rising edges of the second frame = 1010010111000011.
REQ-032 Reset pulsed low after 7 bits, then a full frame 0x001F -> no SSPIF before the full frame, then DataOut=0x000 and SSPIF pulses once.
REQ-033 Frame 0x0010 -> DataOut=0x000, since bit 4 is discarded.
